// File: rtl/accelerator_tensor_finite_difference_if.sv
// rtl/accelerator_tensor_finite_difference_if.sv - control, sample and result bus of the finite-difference block
// Ports (master = frame source/sink, slave = differentiator):
//   start, axis_in, size_i_in, size_j_in, scale_in   frame command, sampled on start
//   ready, error                                     frame completion pulse and reject flag
//   data_in_enable, data_in                          sample stream in
//   data_out_enable, data_out, data_out_i/_j         result stream out with indices
interface accelerator_tensor_finite_difference_if #(
   parameter int DATA_SIZE  = 16,
   parameter int INDEX_SIZE = 16
);
   logic                         start;
   logic                         ready;
   logic                         error;
   logic                         axis_in;
   logic [INDEX_SIZE-1:0]        size_i_in;
   logic [INDEX_SIZE-1:0]        size_j_in;
   logic [DATA_SIZE-1:0]         scale_in;
   logic                         data_in_enable;
   logic signed [DATA_SIZE-1:0]  data_in;
   logic                         data_out_enable;
   logic signed [DATA_SIZE-1:0]  data_out;
   logic [INDEX_SIZE-1:0]        data_out_i;
   logic [INDEX_SIZE-1:0]        data_out_j;

   modport master (
      output start, axis_in, size_i_in, size_j_in, scale_in, data_in_enable, data_in,
      input  ready, error, data_out_enable, data_out, data_out_i, data_out_j
   );

   modport slave (
      input  start, axis_in, size_i_in, size_j_in, scale_in, data_in_enable, data_in,
      output ready, error, data_out_enable, data_out, data_out_i, data_out_j
   );
endinterface

// File: rtl/accelerator_tensor_finite_difference.sv
// rtl/accelerator_tensor_finite_difference.sv - streaming backward-difference differentiator over an I x J matrix
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous reset, active low
//   bus  slave modport: frame command, sample stream in, result stream out, ready/error
module accelerator_tensor_finite_difference #(
   parameter int DATA_SIZE  = 16,
   parameter int INDEX_SIZE = 16,
   parameter int FRAC_BITS  = 8,
   parameter int MAX_J      = 64
) (
   input logic                                  clk,
   input logic                                  rst,
   accelerator_tensor_finite_difference_if.slave bus
);

   localparam int LB_W = (MAX_J > 1) ? $clog2(MAX_J) : 1;
   localparam int PW   = 2 * DATA_SIZE + 2;

   localparam logic [INDEX_SIZE-1:0] MAX_J_W = INDEX_SIZE'(MAX_J);
   localparam logic [INDEX_SIZE-1:0] ONE_W   = INDEX_SIZE'(1);

   localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_SIZE+3){1'b0}}, {(DATA_SIZE-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_SIZE+3){1'b1}}, {(DATA_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                      state;
   logic                        axis_r;
   logic [INDEX_SIZE-1:0]       size_i_r;
   logic [INDEX_SIZE-1:0]       size_j_r;
   logic [DATA_SIZE-1:0]        scale_r;
   logic [INDEX_SIZE-1:0]       i_cnt;
   logic [INDEX_SIZE-1:0]       j_cnt;
   logic signed [DATA_SIZE-1:0] prev_sample;

   // Previous row, indexed by column; only meaningful when differentiating along i
   logic signed [DATA_SIZE-1:0] line_buf [MAX_J];

   logic [LB_W-1:0]             lb_idx;
   logic                        accept;
   logic                        last_i;
   logic                        last_j;
   logic signed [DATA_SIZE-1:0] prev_val;
   logic signed [DATA_SIZE:0]   diff;
   logic signed [PW-1:0]        prod;
   logic signed [PW-1:0]        shifted;
   logic signed [DATA_SIZE-1:0] result;

   always_comb begin
      lb_idx   = j_cnt[LB_W-1:0];
      accept   = (state == RUN) && bus.data_in_enable;
      last_i   = (i_cnt == size_i_r - ONE_W);
      last_j   = (j_cnt == size_j_r - ONE_W);
      prev_val = axis_r ? line_buf[lb_idx] : prev_sample;
      // One extra bit so the difference of two extreme samples cannot wrap
      diff     = $signed({bus.data_in[DATA_SIZE-1], bus.data_in})
               - $signed({prev_val[DATA_SIZE-1], prev_val});
      // Scale is unsigned, so it is zero-extended before the signed multiply
      prod     = diff * $signed({1'b0, scale_r});
      shifted  = prod >>> FRAC_BITS;
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[DATA_SIZE-1:0];
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[DATA_SIZE-1:0];
      end else begin
         result = shifted[DATA_SIZE-1:0];
      end
      // No predecessor exists on the first column (j axis) or first row (i axis)
      if ((!axis_r && j_cnt == '0) || (axis_r && i_cnt == '0)) begin
         result = '0;
      end
   end

   // Read-before-write: the combinational read above sees the old row value
   always_ff @(posedge clk) begin
      if (accept && axis_r) begin
         line_buf[lb_idx] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state               <= IDLE;
         axis_r              <= 1'b0;
         size_i_r            <= '0;
         size_j_r            <= '0;
         scale_r             <= '0;
         i_cnt               <= '0;
         j_cnt               <= '0;
         prev_sample         <= '0;
         bus.ready           <= 1'b0;
         bus.error           <= 1'b0;
         bus.data_out_enable <= 1'b0;
         bus.data_out        <= '0;
         bus.data_out_i      <= '0;
         bus.data_out_j      <= '0;
      end else begin
         bus.ready           <= 1'b0;
         bus.data_out_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  axis_r   <= bus.axis_in;
                  size_i_r <= bus.size_i_in;
                  size_j_r <= bus.size_j_in;
                  scale_r  <= bus.scale_in;
                  i_cnt    <= '0;
                  j_cnt    <= '0;
                  if (bus.size_i_in == '0 || bus.size_j_in == '0) begin
                     bus.error <= 1'b0;
                     state     <= DONE;
                  end else if (bus.axis_in && bus.size_j_in > MAX_J_W) begin
                     bus.error <= 1'b1;
                     state     <= DONE;
                  end else begin
                     bus.error <= 1'b0;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (bus.data_in_enable) begin
                  bus.data_out_enable <= 1'b1;
                  bus.data_out        <= result;
                  bus.data_out_i      <= i_cnt;
                  bus.data_out_j      <= j_cnt;
                  prev_sample         <= bus.data_in;
                  if (last_j) begin
                     j_cnt <= '0;
                     i_cnt <= i_cnt + ONE_W;
                     if (last_i) begin
                        state <= DONE;
                     end
                  end else begin
                     j_cnt <= j_cnt + ONE_W;
                  end
               end
            end
            DONE: begin
               bus.ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accelerator_tensor_finite_difference.sv
// tb/tb_accelerator_tensor_finite_difference.sv - scoreboard bench for accelerator_tensor_finite_difference
module tb_accelerator_tensor_finite_difference;

   localparam int DS = 16;
   localparam int IS = 16;
   localparam int FB = 8;
   localparam int MJ = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   accelerator_tensor_finite_difference_if #(.DATA_SIZE(DS), .INDEX_SIZE(IS)) bus ();

   accelerator_tensor_finite_difference #(
      .DATA_SIZE(DS), .INDEX_SIZE(IS), .FRAC_BITS(FB), .MAX_J(MJ)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int d;
      int i;
      int j;
   } exp_t;

   exp_t sb[$];
   int   smp[$];
   int   ex[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every presented result must match the oldest expectation
   always @(negedge clk) begin
      if (bus.data_out_enable === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0d at (%0d,%0d), expected none",
                     $signed(bus.data_out), bus.data_out_i, bus.data_out_j);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("data_out", longint'($signed(bus.data_out)), e.d);
            check("data_out_i", bus.data_out_i, e.i);
            check("data_out_j", bus.data_out_j, e.j);
         end
      end
   end

   task automatic start_frame(input logic axis, input int si, input int sj, input int scale);
      bus.axis_in   = axis;
      bus.size_i_in = IS'(si);
      bus.size_j_in = IS'(sj);
      bus.scale_in  = DS'(scale);
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      // Scramble command inputs: the frame must use the latched values
      bus.axis_in   = ~axis;
      bus.size_i_in = '0;
      bus.size_j_in = '0;
      bus.scale_in  = '0;
   endtask

   // Called just after the edge that accepted the last sample (or the START)
   task automatic wait_ready(input string name, input logic exp_err);
      int n;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) break;
      end
      check({name, "_ready_latency"}, n, 2);
      check({name, "_error"}, bus.error, exp_err);
      @(negedge clk);
      check({name, "_ready_one_cycle"}, bus.ready, 0);
      #1;
   endtask

   task automatic run_frame(input string name, input logic axis, input int sj, input int scale,
                            input logic gaps, input logic inject);
      int si;
      si = smp.size() / sj;
      start_frame(axis, si, sj, scale);
      for (int k = 0; k < smp.size(); k++) begin
         exp_t e;
         e.d = ex[k];
         e.i = k / sj;
         e.j = k % sj;
         sb.push_back(e);
         if (gaps) begin
            for (int g = 0; g < (k * 3 + 1) % 4; g++) begin
               if (inject && k == 1 && g == 0) begin
                  bus.axis_in   = 1'b1;
                  bus.size_i_in = 16'd5;
                  bus.size_j_in = 16'd5;
                  bus.scale_in  = 16'd1;
                  bus.start     = 1'b1;
               end
               tick();
               bus.start = 1'b0;
            end
         end
         bus.data_in        = DS'(smp[k]);
         bus.data_in_enable = 1'b1;
         tick();
         bus.data_in_enable = 1'b0;
      end
      wait_ready(name, 1'b0);
   endtask

   initial begin
      int rdy_cnt;
      bus.start          = 1'b0;
      bus.axis_in        = 1'b0;
      bus.size_i_in      = '0;
      bus.size_j_in      = '0;
      bus.scale_in       = '0;
      bus.data_in_enable = 1'b0;
      bus.data_in        = '0;
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_enable", bus.data_out_enable, 0);
      check("reset_ready", bus.ready, 0);
      check("reset_error", bus.error, 0);
      check("reset_data", bus.data_out, 0);
      check("reset_i", bus.data_out_i, 0);
      check("reset_j", bus.data_out_j, 0);
      rst = 1'b1;
      tick();

      smp = '{1, 4, 9, 16};   ex = '{0, 3, 5, 7};
      run_frame("axis_j_1x4", 1'b0, 4, 256, 1'b0, 1'b0);

      smp = '{1, 2, 3, 5, 7, 9};   ex = '{0, 0, 0, 4, 5, 6};
      run_frame("axis_i_2x3", 1'b1, 3, 256, 1'b0, 1'b0);

      // 640>>>8 = 2, and -640>>>8 floors to -3
      smp = '{0, 5, 0};   ex = '{0, 2, -3};
      run_frame("scale_half", 1'b0, 3, 128, 1'b0, 1'b0);

      smp = '{32767, -32768};   ex = '{0, -32768};
      run_frame("sat_neg", 1'b0, 2, 256, 1'b0, 1'b0);

      smp = '{0, 20000};   ex = '{0, 32767};
      run_frame("sat_pos", 1'b0, 2, 512, 1'b0, 1'b0);

      start_frame(1'b1, 2, MJ + 1, 256);
      wait_ready("reject_wide", 1'b1);

      start_frame(1'b0, 0, 4, 256);
      wait_ready("size_i_zero", 1'b0);

      smp = '{2, 7, 3};   ex = '{0, 5, -4};
      run_frame("bubbles", 1'b0, 3, 256, 1'b1, 1'b1);

      // Sample enable while idle must not produce any output
      bus.data_in        = 16'd123;
      bus.data_in_enable = 1'b1;
      repeat (4) tick();
      bus.data_in_enable = 1'b0;

      // Abort a 2x3 frame after two samples
      start_frame(1'b0, 2, 3, 256);
      smp = '{10, 13};   ex = '{0, 3};
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         e.d = ex[k];
         e.i = 0;
         e.j = k;
         sb.push_back(e);
         bus.data_in        = DS'(smp[k]);
         bus.data_in_enable = 1'b1;
         tick();
         bus.data_in_enable = 1'b0;
      end
      rst = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("abort_enable", bus.data_out_enable, 0);
      check("abort_data", bus.data_out, 0);
      check("abort_i", bus.data_out_i, 0);
      check("abort_j", bus.data_out_j, 0);
      rst = 1'b1;
      rdy_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.ready === 1'b1) rdy_cnt++;
      end
      check("abort_no_ready", rdy_cnt, 0);
      #1;

      smp = '{1, 2, 4, 8, 0, -3};   ex = '{0, 0, 3, 6, -4, -11};
      run_frame("after_abort_3x2", 1'b1, 2, 256, 1'b0, 1'b0);

      repeat (3) tick();
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
